// File: rtl/cpu_pkg.sv
// Shared CPU definitions for the fetch stage.
//   fetch_state_e : fetch FSM states
//   INST_W, PC_W  : instruction and PC widths
//   NOP_INST      : word presented on inst_out during a bubble
package cpu_pkg;

  localparam int unsigned INST_W = 32;
  localparam int unsigned PC_W   = 32;

  localparam logic [INST_W-1:0] NOP_INST = 32'h0000_0000;

  typedef enum logic [1:0] {
    StFetch,
    StWait,
    StHold,
    StDrop
  } fetch_state_e;

endpackage

// File: rtl/if_hold_buf.sv
// Single-word instruction buffer with a valid bit. Holds a returned word while the pipeline
// is stalled.
//   clk_i   : clock
//   rst_i   : synchronous active-high reset (clears valid)
//   load_i  : capture data_i and set valid (wins over clear_i)
//   clear_i : drop the buffered word
//   data_i  : word to capture
//   data_o  : buffered word
//   valid_o : buffer holds a word
module if_hold_buf
  import cpu_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              load_i,
  input  logic              clear_i,
  input  logic [INST_W-1:0] data_i,
  output logic [INST_W-1:0] data_o,
  output logic              valid_o
);

  logic [INST_W-1:0] data_d, data_q;
  logic              valid_d, valid_q;

  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    if (clear_i) begin
      valid_d = 1'b0;
    end
    if (load_i) begin
      data_d  = data_i;
      valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      data_q  <= NOP_INST;
      valid_q <= 1'b0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  assign data_o  = data_q;
  assign valid_o = valid_q;

endmodule

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage. Owns the PC, issues one instruction-memory request at a time and
// presents {inst, pc+4, bubble} to the IF/ID register. Holds its outputs on stall and absorbs
// redirects from execute.
//   clk, rst                  : clock, synchronous active-high reset
//   stall                     : hold outputs, do not deliver
//   redirect_valid/pc         : load new PC, flush any in-flight fetch
//   imem_req/addr/ready       : request handshake (req combinational)
//   imem_rvalid/rdata         : read response
//   inst_out/pcplus4_out      : registered instruction and its PC+4
//   bubble_out                : registered; outputs are not a valid instruction
//   pc_out                    : current fetch PC
module if_fetch_stage
  import cpu_pkg::*;
#(
  parameter logic [PC_W-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              redirect_valid,
  input  logic [PC_W-1:0]   redirect_pc,
  output logic              imem_req,
  output logic [PC_W-1:0]   imem_addr,
  input  logic              imem_ready,
  input  logic              imem_rvalid,
  input  logic [INST_W-1:0] imem_rdata,
  output logic [INST_W-1:0] inst_out,
  output logic [PC_W-1:0]   pcplus4_out,
  output logic              bubble_out,
  output logic [PC_W-1:0]   pc_out
);

  fetch_state_e      state_d, state_q;
  logic [PC_W-1:0]   pc_d, pc_q;
  logic [INST_W-1:0] inst_d, inst_q;
  logic [PC_W-1:0]   pcplus4_d, pcplus4_q;
  logic              bubble_d, bubble_q;

  logic [PC_W-1:0]   pc_plus4;
  logic              deliver;
  logic [INST_W-1:0] word;
  logic              buf_load, buf_clear, buf_valid;
  logic [INST_W-1:0] buf_data;

  assign pc_plus4 = pc_q + 32'd4;

  if_hold_buf u_hold_buf (
    .clk_i   (clk),
    .rst_i   (rst),
    .load_i  (buf_load),
    .clear_i (buf_clear),
    .data_i  (imem_rdata),
    .data_o  (buf_data),
    .valid_o (buf_valid)
  );

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    inst_d    = inst_q;
    pcplus4_d = pcplus4_q;
    bubble_d  = bubble_q;
    buf_load  = 1'b0;
    buf_clear = 1'b0;
    deliver   = 1'b0;
    word      = NOP_INST;

    if (redirect_valid) begin
      pc_d      = {redirect_pc[PC_W-1:2], 2'b00};
      buf_clear = 1'b1;
      // A request accepted this cycle, or still outstanding, leaves one response to discard.
      unique case (state_q)
        StFetch:        state_d = imem_ready  ? StDrop  : StFetch;
        StWait, StDrop: state_d = imem_rvalid ? StFetch : StDrop;
        StHold:         state_d = StFetch;
        default:        state_d = StFetch;
      endcase
    end else begin
      unique case (state_q)
        StFetch: begin
          if (imem_ready) state_d = StWait;
        end
        StWait: begin
          if (imem_rvalid) begin
            if (stall) begin
              buf_load = 1'b1;
              state_d  = StHold;
            end else begin
              deliver = 1'b1;
              word    = imem_rdata;
              state_d = StFetch;
            end
          end
        end
        StHold: begin
          if (!stall && buf_valid) begin
            deliver   = 1'b1;
            word      = buf_data;
            buf_clear = 1'b1;
            state_d   = StFetch;
          end
        end
        StDrop: begin
          if (imem_rvalid) state_d = StFetch;
        end
        default: state_d = StFetch;
      endcase
    end

    if (redirect_valid) begin
      inst_d    = NOP_INST;
      pcplus4_d = '0;
      bubble_d  = 1'b1;
    end else if (deliver) begin
      inst_d    = word;
      pcplus4_d = pc_plus4;
      bubble_d  = 1'b0;
      pc_d      = pc_plus4;
    end else if (!stall) begin
      inst_d    = NOP_INST;
      pcplus4_d = '0;
      bubble_d  = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StFetch;
      pc_q      <= RESET_PC;
      inst_q    <= NOP_INST;
      pcplus4_q <= '0;
      bubble_q  <= 1'b1;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      inst_q    <= inst_d;
      pcplus4_q <= pcplus4_d;
      bubble_q  <= bubble_d;
    end
  end

  assign imem_req    = (state_q == StFetch) && !rst;
  assign imem_addr   = pc_q;
  assign inst_out    = inst_q;
  assign pcplus4_out = pcplus4_q;
  assign bubble_out  = bubble_q;
  assign pc_out      = pc_q;

endmodule

// File: tb/tb_if_fetch_stage.sv
module tb_if_fetch_stage;

  logic        clk = 1'b0;
  logic        rst, stall, redirect_valid, imem_ready, imem_rvalid;
  logic [31:0] redirect_pc, imem_rdata;
  logic        imem_req, bubble_out;
  logic [31:0] imem_addr, inst_out, pcplus4_out, pc_out;

  // Second instance parked at the top of the address space for the wrap case.
  logic        w_rst, w_ready, w_rvalid, w_req, w_bubble;
  logic [31:0] w_rdata, w_addr, w_inst, w_pc4, w_pc;

  always #5 clk = ~clk;

  if_fetch_stage dut (
    .clk            (clk),
    .rst            (rst),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_ready     (imem_ready),
    .imem_rvalid    (imem_rvalid),
    .imem_rdata     (imem_rdata),
    .inst_out       (inst_out),
    .pcplus4_out    (pcplus4_out),
    .bubble_out     (bubble_out),
    .pc_out         (pc_out)
  );

  if_fetch_stage #(.RESET_PC(32'hFFFF_FFFC)) dut_w (
    .clk            (clk),
    .rst            (w_rst),
    .stall          (1'b0),
    .redirect_valid (1'b0),
    .redirect_pc    (32'h0),
    .imem_req       (w_req),
    .imem_addr      (w_addr),
    .imem_ready     (w_ready),
    .imem_rvalid    (w_rvalid),
    .imem_rdata     (w_rdata),
    .inst_out       (w_inst),
    .pcplus4_out    (w_pc4),
    .bubble_out     (w_bubble),
    .pc_out         (w_pc)
  );

  int passed = 0;
  int total  = 0;

  // Transaction-level reference: PC, one outstanding request (maybe doomed), a parked word.
  logic [31:0] m_pc, m_held, m_inst, m_pc4;
  logic        m_out, m_drop, m_held_v, m_bub;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic model_reset();
    m_pc = 32'h0; m_out = 1'b0; m_drop = 1'b0; m_held_v = 1'b0; m_held = 32'h0;
    m_inst = 32'h0; m_pc4 = 32'h0; m_bub = 1'b1;
  endtask

  // Drive one cycle (called at negedge), check combinational outputs, advance, check registers.
  task automatic step(input logic s, input logic r, input logic [31:0] rpc, input logic rdy,
                      input logic rv, input logic [31:0] rd, input logic rs);
    logic        exp_req, acc, dlv;
    logic [31:0] w;
    rv = rv && m_out;  // memory may only answer an accepted request
    rst = rs; stall = s; redirect_valid = r; redirect_pc = rpc;
    imem_ready = rdy; imem_rvalid = rv; imem_rdata = rd;
    #1;
    exp_req = !m_out && !m_held_v && !rs;
    chk("imem_req", {31'b0, imem_req}, {31'b0, exp_req});
    if (exp_req) chk("imem_addr", imem_addr, m_pc);
    chk("pc_out", pc_out, m_pc);
    @(posedge clk);
    acc = exp_req && rdy;
    dlv = 1'b0;
    w   = 32'h0;
    if (rs) begin
      model_reset();
    end else if (r) begin
      m_pc = rpc & 32'hFFFF_FFFC;
      m_held_v = 1'b0;
      if (m_out) begin
        if (rv) begin m_out = 1'b0; m_drop = 1'b0; end
        else m_drop = 1'b1;
      end
      if (acc) begin m_out = 1'b1; m_drop = 1'b1; end
      m_inst = 32'h0; m_pc4 = 32'h0; m_bub = 1'b1;
    end else begin
      if (m_held_v && !s) begin
        dlv = 1'b1; w = m_held; m_held_v = 1'b0;
      end else if (m_out && rv) begin
        m_out = 1'b0;
        if (m_drop) m_drop = 1'b0;
        else if (s) begin m_held = rd; m_held_v = 1'b1; end
        else begin dlv = 1'b1; w = rd; end
      end
      if (acc) begin m_out = 1'b1; m_drop = 1'b0; end
      if (dlv) begin
        m_inst = w; m_pc4 = m_pc + 32'd4; m_bub = 1'b0; m_pc = m_pc + 32'd4;
      end else if (!s) begin
        m_inst = 32'h0; m_pc4 = 32'h0; m_bub = 1'b1;
      end
    end
    @(negedge clk);
    chk("inst_out", inst_out, m_inst);
    chk("pcplus4_out", pcplus4_out, m_pc4);
    chk("bubble_out", {31'b0, bubble_out}, {31'b0, m_bub});
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0;
    imem_ready = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'h0;
    w_rst = 1'b1; w_ready = 1'b0; w_rvalid = 1'b0; w_rdata = 32'h0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    chk("rst_inst", inst_out, 32'h0);
    chk("rst_pc4", pcplus4_out, 32'h0);
    chk("rst_bubble", {31'b0, bubble_out}, 32'h1);
    chk("rst_pc", pc_out, 32'h0);

    // Streaming fetch: addresses 0,4,8,12 with a bubble between deliveries.
    for (int i = 0; i < 4; i++) begin
      step(0, 0, 0, 1, 0, 0, 0);
      step(0, 0, 0, 1, 1, $urandom, 0);
      chk("t1_pc4", pcplus4_out, 32'(4 * (i + 1)));
      chk("t1_bubble", {31'b0, bubble_out}, 32'h0);
    end

    // Stall while waiting: word parked, outputs frozen, released on stall drop.
    step(0, 0, 0, 1, 0, 0, 0);
    step(0, 0, 0, 0, 1, 32'h1111_1111, 0);
    step(1, 0, 0, 1, 0, 0, 0);
    chk("t2_frozen0", inst_out, 32'h1111_1111);
    step(1, 0, 0, 0, 1, 32'hDEAD_BEEF, 0);
    chk("t2_frozen1", inst_out, 32'h1111_1111);
    step(1, 0, 0, 1, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0);
    chk("t2_inst", inst_out, 32'hDEAD_BEEF);
    chk("t2_pc4", pcplus4_out, 32'd24);

    // Redirect while waiting; the late response is discarded.
    step(0, 0, 0, 1, 0, 0, 0);
    step(0, 1, 32'h100, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1, 32'h1234, 0);
    chk("t3_bubble", {31'b0, bubble_out}, 32'h1);
    chk("t3_inst", inst_out, 32'h0);
    chk("t3_addr", imem_addr, 32'h100);
    step(0, 0, 0, 1, 0, 0, 0);
    step(0, 0, 0, 0, 1, $urandom, 0);

    // Redirect plus stall while holding a word; misaligned target.
    step(0, 0, 0, 1, 0, 0, 0);
    step(1, 0, 0, 0, 1, 32'hCAFE, 0);
    step(1, 1, 32'h203, 0, 0, 0, 0);
    chk("t4_bubble", {31'b0, bubble_out}, 32'h1);
    chk("t4_pc", pc_out, 32'h200);
    chk("t4_addr", imem_addr, 32'h200);

    // Reset in the middle of a request.
    step(0, 0, 0, 1, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 1);
    rst = 1'b0;
    #1;
    chk("t6_req", {31'b0, imem_req}, 32'h1);
    chk("t6_addr", imem_addr, 32'h0);
    chk("t6_bubble", {31'b0, bubble_out}, 32'h1);
    chk("t6_inst", inst_out, 32'h0);
    @(negedge clk);

    // Random traffic against the reference.
    for (int i = 0; i < 1500; i++) begin
      step($urandom_range(0, 3) == 0, $urandom_range(0, 11) == 0, $urandom,
           $urandom_range(0, 9) < 7, $urandom_range(0, 1) == 1, $urandom,
           $urandom_range(0, 99) == 0);
    end

    // PC+4 wraps from the top of the address space.
    chk("w_rst_pc", w_pc, 32'hFFFF_FFFC);
    w_rst = 1'b0;
    #1;
    chk("w_req", {31'b0, w_req}, 32'h1);
    chk("w_addr0", w_addr, 32'hFFFF_FFFC);
    w_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    w_ready = 1'b0; w_rvalid = 1'b1; w_rdata = 32'h13;
    @(posedge clk);
    @(negedge clk);
    w_rvalid = 1'b0;
    chk("w_inst", w_inst, 32'h13);
    chk("w_pc4", w_pc4, 32'h0);
    chk("w_bubble", {31'b0, w_bubble}, 32'h0);
    chk("w_addr1", w_addr, 32'h0);
    chk("w_req1", {31'b0, w_req}, 32'h1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
